// File: rtl/multiplexor_display.sv
// multiplexor_display
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment
//   display. Latches an N-nibble hex value into shadow registers, scans the
//   digits at a programmable rate and drives one 5-bit decoder code per slot
//   together with the matching active-low anode enable.
//
//   Optional feature macro: MULTIPLEXOR_BLANCO_CEROS_EN (leading-zero blanking)
//
// Parameters
//   N_DIGITOS    number of digits scanned (2..8)
//   DIV_REFRESCO clock cycles each digit slot lasts (>= 4)
//   BLANQUEO     dark cycles at the start of every slot (< DIV_REFRESCO)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   valor      hex nibbles, nibble 0 = rightmost digit
//   cargar     single-cycle strobe latching valor/error into the shadows
//   error      latched with cargar; when set every digit shows a dash (17)
//   habilitar  scan enable; low = display dark and scan frozen
//   hex        digit code to the decoder (0-15 hex, 16 blank, 17 dash)
//   anodos     active-low digit enables, at most one low
//   digito     index of the digit currently addressed
module multiplexor_display #(
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 50000,
  parameter int BLANQUEO     = 2,
  localparam int DW          = $clog2(N_DIGITOS),
  localparam int CW          = $clog2(DIV_REFRESCO)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*N_DIGITOS-1:0] valor,
  input  logic                   cargar,
  input  logic                   error,
  input  logic                   habilitar,
  output logic [4:0]             hex,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic [DW-1:0]          digito
);

  localparam logic [4:0] COD_BLANCO = 5'd16;
  localparam logic [4:0] COD_GUION  = 5'd17;

  typedef enum logic {
    APAGADO,
    ENCENDIDO
  } fase_t;

  logic [4*N_DIGITOS-1:0] r_sombra;
  logic                   r_err;
  logic [CW-1:0]          r_cnt;
  logic [4:0]             r_codigo;   // code of the current slot, kept while disabled

  logic                   w_cnt_fin;
  logic [CW-1:0]          w_cnt_sig;
  logic [DW-1:0]          w_dig_sig;
  logic [4:0]             w_codigo_sig;
  fase_t                  w_fase_sig;
  logic [N_DIGITOS-1:0]   w_anodo_on;

  // Decoder code for digit idx taken from the shadow registers.
  function automatic logic [4:0] f_codigo(input logic [DW-1:0]          idx,
                                          input logic [4*N_DIGITOS-1:0] s,
                                          input logic                   e);
    logic [3:0] nib;
    logic       blanco;
    nib    = '0;
    blanco = 1'b0;
    for (int unsigned k = 0; k < N_DIGITOS; k++) begin
      if (DW'(k) == idx) nib = s[4*k +: 4];
    end
`ifdef MULTIPLEXOR_BLANCO_CEROS_EN
    // Blank when this digit and every more significant one are zero;
    // digit 0 is never blanked so a zero value still shows "0".
    blanco = (idx != '0);
    for (int unsigned k = 1; k < N_DIGITOS; k++) begin
      if ((DW'(k) >= idx) && (s[4*k +: 4] != 4'd0)) blanco = 1'b0;
    end
`endif
    if (e)           return COD_GUION;
    else if (blanco) return COD_BLANCO;
    else             return {1'b0, nib};
  endfunction

  always_comb begin
    w_cnt_fin    = (r_cnt == CW'(DIV_REFRESCO - 1));
    w_cnt_sig    = w_cnt_fin ? '0 : r_cnt + 1'b1;
    w_dig_sig    = digito;
    if (w_cnt_fin) begin
      w_dig_sig = (digito == DW'(N_DIGITOS - 1)) ? '0 : digito + 1'b1;
    end
    // The code is chosen only at the digit advance so a cargar in mid-slot
    // never changes the digit already being shown.
    w_codigo_sig = w_cnt_fin ? f_codigo(w_dig_sig, r_sombra, r_err) : r_codigo;
    w_fase_sig   = (w_cnt_sig >= CW'(BLANQUEO)) ? ENCENDIDO : APAGADO;
    w_anodo_on   = ~(N_DIGITOS'(1) << w_dig_sig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sombra <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      digito   <= '0;
      r_codigo <= 5'd0;        // digit 0 of an all-zero shadow
      hex      <= COD_BLANCO;
      anodos   <= '1;
    end else begin
      if (cargar) begin
        r_sombra <= valor;
        r_err    <= error;
      end
      if (habilitar) begin
        r_cnt    <= w_cnt_sig;
        digito   <= w_dig_sig;
        r_codigo <= w_codigo_sig;
        hex      <= w_codigo_sig;
        anodos   <= (w_fase_sig == ENCENDIDO) ? w_anodo_on : '1;
      end else begin
        hex      <= COD_BLANCO;
        anodos   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_multiplexor_display.sv
module tb_multiplexor_display;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BL  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] valor = '0;
  logic        cargar = 1'b0;
  logic        error = 1'b0;
  logic        habilitar = 1'b0;
  logic [4:0]  hex;
  logic [3:0]  anodos;
  logic [1:0]  digito;

  multiplexor_display #(
    .N_DIGITOS   (N),
    .DIV_REFRESCO(DIV),
    .BLANQUEO    (BL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valor    (valor),
    .cargar   (cargar),
    .error    (error),
    .habilitar(habilitar),
    .hex      (hex),
    .anodos   (anodos),
    .digito   (digito)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0] lit(input int d);
    logic [3:0] x;
    x = 4'b1 << d;
    return ~x;
  endfunction

  // Reference: scan position as a single counter over the whole frame.
  function automatic logic [4:0] ref_code(input int d, input logic [15:0] s, input logic e);
    logic [15:0] alto;
    alto = s >> (4 * d);
    if (e) return 5'd17;
`ifdef MULTIPLEXOR_BLANCO_CEROS_EN
    if (d > 0 && alto == 16'd0) return 5'd16;
`endif
    return 5'(alto & 16'hF);
  endfunction

  int          m_pos  = 0;
  logic [15:0] m_s    = '0;
  logic        m_err  = 1'b0;
  logic [4:0]  m_code = 5'd0;
  logic        m_hab  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  <= 0;
      m_s    <= '0;
      m_err  <= 1'b0;
      m_code <= 5'd0;
      m_hab  <= 1'b0;
    end else begin
      m_hab <= habilitar;
      if (habilitar) begin
        m_pos <= (m_pos + 1) % (N * DIV);
        if ((m_pos + 1) % DIV == 0)
          m_code <= ref_code(((m_pos + 1) % (N * DIV)) / DIV, m_s, m_err);
      end
      if (cargar) begin
        m_s   <= valor;
        m_err <= error;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      automatic int         e_dig = m_pos / DIV;
      automatic int         e_hex = m_hab ? int'(m_code) : 16;
      automatic logic [3:0] e_an  = (m_hab && (m_pos % DIV) >= BL) ? lit(e_dig) : 4'hF;
      check("model_digito", int'(digito), e_dig);
      check("model_hex", int'(hex), e_hex);
      check("model_anodos", int'(anodos), int'(e_an));
    end
  end

  // Returns at the first negedge where digit d has just become lit.
  task automatic wait_lit(input int d);
    bit prev;
    prev = (anodos == lit(d));
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (anodos == lit(d) && !prev) return;
      prev = (anodos == lit(d));
    end
    n_total++;
    $display("FAIL wait_lit_timeout: digit %0d never lit, got anodos %b", d, anodos);
  endtask

  task automatic load(input logic [15:0] v, input logic e);
    valor  = v;
    error  = e;
    cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
  endtask

  task automatic scan_check(input string name, input logic [15:0] v, input logic e,
                            input int e0, input int e1, input int e2, input int e3);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    wait_lit(3);
    load(v, e);
    for (int d = 0; d < 4; d++) begin
      wait_lit(d);
      check({name, "_digito"}, int'(digito), d);
      check({name, "_hex"}, int'(hex), exp[d]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_total);
    $fatal(1);
  end

  initial begin
    int n_on;
    #2 rst_n = 1'b0;
    habilitar = 1'b1;
    @(negedge clk);
    check("reset_hex", int'(hex), 16);
    check("reset_anodos", int'(anodos), 15);
    check("reset_digito", int'(digito), 0);
    rst_n = 1'b1;
    #1;
    check("first_dark_anodos", int'(anodos), 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("first_slot_anodos", int'(anodos), 14);
      check("first_slot_hex", int'(hex), 0);
    end
    @(negedge clk);
    check("first_advance_digito", int'(digito), 1);
    check("first_advance_anodos", int'(anodos), 15);

    scan_check("scan_3A0F", 16'h3A0F, 1'b0, 15, 0, 10, 3);
`ifdef MULTIPLEXOR_BLANCO_CEROS_EN
    scan_check("scan_0050", 16'h0050, 1'b0, 0, 5, 16, 16);
    scan_check("scan_0000", 16'h0000, 1'b0, 0, 16, 16, 16);
`else
    scan_check("scan_0050", 16'h0050, 1'b0, 0, 5, 0, 0);
    scan_check("scan_0000", 16'h0000, 1'b0, 0, 0, 0, 0);
`endif
    scan_check("scan_error", 16'($urandom), 1'b1, 17, 17, 17, 17);
    scan_check("scan_1234", 16'h1234, 1'b0, 4, 3, 2, 1);

    // Freeze mid-slot on digit 2 (one lit cycle already spent).
    wait_lit(2);
    habilitar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_anodos", int'(anodos), 15);
      check("hold_hex", int'(hex), 16);
      check("hold_digito", int'(digito), 2);
    end
    habilitar = 1'b1;
    n_on = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (digito != 2) break;
      if (anodos == lit(2)) begin
        n_on++;
        check("resume_hex", int'(hex), 2);
      end
    end
    check("resume_lit_cycles", n_on, DIV - BL - 1);

    for (int i = 0; i < 800; i++) begin
      habilitar = ($urandom_range(0, 9) != 0);
      cargar    = ($urandom_range(0, 7) == 0);
      error     = ($urandom_range(0, 15) == 0);
      valor     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      @(negedge clk);
    end

    cargar    = 1'b0;
    error     = 1'b0;
    habilitar = 1'b1;
    load(16'hBEEF, 1'b0);
    wait_lit(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_hex", int'(hex), 16);
    check("async_reset_anodos", int'(anodos), 15);
    check("async_reset_digito", int'(digito), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_lit(0);
    check("post_reset_hex", int'(hex), 0);
    wait_lit(1);
`ifdef MULTIPLEXOR_BLANCO_CEROS_EN
    check("post_reset_hex1", int'(hex), 16);
`else
    check("post_reset_hex1", int'(hex), 0);
`endif
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
